// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit, one data-memory transaction at a time
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  state_t      state_q, state_d;
  logic        cap_we, cap_unsigned;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr, cap_wdata;
  logic [4:0]  cap_rd;
  logic        misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, shifted, load_data;

  always_comb begin
    misaligned = (req_size_i == 2'b11)
               | ((req_size_i == 2'b01) & req_addr_i[0])
               | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = misaligned ? ERR : REQ;
      REQ:  if (dmem_gnt_i) state_d = cap_we ? IDLE : WAIT;
      WAIT: if (dmem_rvalid_i) state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cap_we       <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_rd       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        cap_we       <= req_we_i;
        cap_size     <= req_size_i;
        cap_unsigned <= req_unsigned_i;
        cap_addr     <= req_addr_i;
        cap_wdata    <= req_wdata_i;
        cap_rd       <= req_rd_i;
      end
    end
  end

  // Store lanes: sub-word data is replicated so the enabled lane always carries it.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = cap_wdata;
    if (cap_we) begin
      case (cap_size)
        2'b00: begin
          lane_be    = 4'b0001 << cap_addr[1:0];
          lane_wdata = {4{cap_wdata[7:0]}};
        end
        2'b01: begin
          lane_be    = 4'b0011 << {cap_addr[1], 1'b0};
          lane_wdata = {2{cap_wdata[15:0]}};
        end
        default: begin
          lane_be    = 4'b1111;
          lane_wdata = cap_wdata;
        end
      endcase
    end
  end

  always_comb begin
    stall_o      = (state_q != IDLE);
    err_o        = (state_q == ERR);
    dmem_req_o   = (state_q == REQ);
    dmem_we_o    = dmem_req_o & cap_we;
    dmem_addr_o  = dmem_req_o ? {cap_addr[31:2], 2'b00} : 32'h0;
    dmem_be_o    = dmem_req_o ? lane_be : 4'b0000;
    dmem_wdata_o = dmem_req_o ? lane_wdata : 32'h0;
  end

  always_comb begin
    shifted = dmem_rdata_i >> {cap_addr[1:0], 3'b000};
    case (cap_size)
      2'b00:   load_data = {{24{~cap_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~cap_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Loads targeting x0 still complete on the bus but never signal writeback.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
    end else begin
      wb_valid_o <= (state_q == WAIT) && dmem_rvalid_i && (cap_rd != 5'd0);
      if (state_q == WAIT && dmem_rvalid_i) begin
        wb_rd_o   <= cap_rd;
        wb_data_o <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;
  int wb_count = 0;
  int wb_base;

  mem_access_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (wb_valid_o) wb_count <= wb_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request during one IDLE cycle; returns one cycle after acceptance (c1).
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    issue(1'b0, size, uns, addr, 32'h0, rd);
    check({tag, ".c1_stall"}, stall_o, 1);
    check({tag, ".c1_req"}, dmem_req_o, 1);
    check({tag, ".c1_we"}, dmem_we_o, 0);
    check({tag, ".c1_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
    check({tag, ".c1_be"}, dmem_be_o, 4'b1111);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check({tag, ".c2_stall"}, stall_o, 1);
    check({tag, ".c2_req"}, dmem_req_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
    check({tag, ".c3_wbv"}, wb_valid_o, (rd != 5'd0) ? 1 : 0);
    if (rd != 5'd0) begin
      check({tag, ".c3_rd"}, wb_rd_o, rd);
      check({tag, ".c3_data"}, wb_data_o, exp_data);
    end
    check({tag, ".c3_stall"}, stall_o, 0);
    tick();
    check({tag, ".c4_wbv"}, wb_valid_o, 0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    wb_base = wb_count;
    issue(1'b1, size, 1'b0, addr, wdata, 5'd9);
    check({tag, ".req"}, dmem_req_o, 1);
    check({tag, ".we"}, dmem_we_o, 1);
    check({tag, ".addr"}, dmem_addr_o, {addr[31:2], 2'b00});
    check({tag, ".be"}, dmem_be_o, exp_be);
    check({tag, ".wdata"}, dmem_wdata_o, exp_wdata);
    check({tag, ".c1_stall"}, stall_o, 1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check({tag, ".c2_stall"}, stall_o, 0);
    check({tag, ".c2_req"}, dmem_req_o, 0);
    tick();
    check({tag, ".no_wb"}, wb_count - wb_base, 0);
  endtask

  task automatic do_err(input string tag, input logic [1:0] size, input logic [31:0] addr);
    wb_base = wb_count;
    issue(1'b0, size, 1'b0, addr, 32'h0, 5'd4);
    check({tag, ".c1_err"}, err_o, 1);
    check({tag, ".c1_req"}, dmem_req_o, 0);
    check({tag, ".c1_stall"}, stall_o, 1);
    tick();
    check({tag, ".c2_err"}, err_o, 0);
    check({tag, ".c2_req"}, dmem_req_o, 0);
    check({tag, ".c2_stall"}, stall_o, 0);
    tick();
    check({tag, ".no_wb"}, wb_count - wb_base, 0);
  endtask

  initial begin
    tick();
    tick();
    check("rst.stall", stall_o, 0);
    check("rst.req", dmem_req_o, 0);
    check("rst.be", dmem_be_o, 0);
    check("rst.addr", dmem_addr_o, 0);
    check("rst.wbv", wb_valid_o, 0);
    check("rst.err", err_o, 0);
    rst_i = 1'b0;
    tick();

    do_load("lw", 32'h0000_0104, 2'b10, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb_s", 32'h0000_0203, 2'b00, 1'b0, 5'd6, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lb_u", 32'h0000_0203, 2'b00, 1'b1, 5'd6, 32'h80FF_0000, 32'h0000_0080);
    do_load("lh_s", 32'h0000_0202, 2'b01, 1'b0, 5'd8, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lbu1", 32'h0000_0211, 2'b00, 1'b1, 5'd2, 32'h1122_3344, 32'h0000_0033);
    do_load("lhu0", 32'h0000_0210, 2'b01, 1'b1, 5'd3, 32'h1122_F344, 32'h0000_F344);

    do_store("sb", 32'h0000_0301, 2'b00, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
    do_store("sh", 32'h0000_0302, 2'b01, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    do_store("sw", 32'h0000_0308, 2'b10, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Backpressure: grant withheld four cycles, rvalid three cycles after grant.
    wb_base = wb_count;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0208, 32'h0, 5'd7);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      check("bp.req", dmem_req_o, 1);
      check("bp.addr", dmem_addr_o, 32'h0000_0208);
      check("bp.be", dmem_be_o, 4'b1111);
      check("bp.we", dmem_we_o, 0);
      check("bp.stall", stall_o, 1);
      tick();
    end
    dmem_rvalid_i = 1'b0;
    check("bp.gnt_req", dmem_req_o, 1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp.wait_stall", stall_o, 1);
      check("bp.wait_req", dmem_req_o, 0);
      check("bp.wait_wbv", wb_valid_o, 0);
      tick();
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0123_4567;
    tick();
    dmem_rvalid_i = 1'b0;
    check("bp.wbv", wb_valid_o, 1);
    check("bp.rd", wb_rd_o, 5'd7);
    check("bp.data", wb_data_o, 32'h0123_4567);
    check("bp.stall_end", stall_o, 0);
    tick();
    check("bp.one_wb", wb_count - wb_base, 1);

    do_err("misal_w", 2'b10, 32'h0000_0102);
    do_err("misal_h", 2'b01, 32'h0000_0101);
    do_err("size11", 2'b11, 32'h0000_0100);

    wb_base = wb_count;
    do_load("rd0", 32'h0000_0400, 2'b10, 1'b0, 5'd0, 32'h5555_AAAA, 32'h0);
    check("rd0.no_wb", wb_count - wb_base, 0);

    // Reset while waiting for read data; the late rvalid must be dropped.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd3);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("rmid.wait_stall", stall_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rmid.stall", stall_o, 0);
    check("rmid.req", dmem_req_o, 0);
    check("rmid.we", dmem_we_o, 0);
    check("rmid.addr", dmem_addr_o, 0);
    check("rmid.be", dmem_be_o, 0);
    check("rmid.wdata", dmem_wdata_o, 0);
    check("rmid.wbv", wb_valid_o, 0);
    check("rmid.wbrd", wb_rd_o, 0);
    check("rmid.wbdata", wb_data_o, 0);
    check("rmid.err", err_o, 0);
    wb_base = wb_count;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    tick();
    dmem_rvalid_i = 1'b0;
    check("rmid.late_wbv", wb_valid_o, 0);
    check("rmid.late_stall", stall_o, 0);
    tick();
    check("rmid.no_wb", wb_count - wb_base, 0);
    do_load("post_rst", 32'h0000_0044, 2'b10, 1'b0, 5'd12, 32'h1357_9BDF, 32'h1357_9BDF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
